// File: rtl/register_load_arbiter_pkg.sv
// Shared constants and state encoding for the register load arbiter.
package register_load_arbiter_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 1;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 2;
   localparam int unsigned NUM_REQ            = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/register_load_arbiter_pick.sv
// Two-requester grant selection; REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN selects
// round-robin (pointer names the preferred requester) over fixed priority.
module register_load_arbiter_pick
   import register_load_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
   input  logic               ptr,
`endif
   output logic [NUM_REQ-1:0] grant_c
);

   always_comb begin
      grant_c = '0;
`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
      if (req == 2'b11)  grant_c = ptr ? 2'b10 : 2'b01;
      else if (req[0])   grant_c = 2'b01;
      else if (req[1])   grant_c = 2'b10;
`else
      if (req[0])        grant_c = 2'b01;
      else if (req[1])   grant_c = 2'b10;
`endif
   end

endmodule

// File: rtl/register_load_arbiter.sv
// Arbitrates two writers onto a shared bus of falling-edge registers.
// Build with REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN for round-robin grants.
module register_load_arbiter
   import register_load_arbiter_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH
)(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [NUM_REQ-1:0]    Req,
   input  logic [ADDR_WIDTH-1:0] Addr0,
   input  logic [ADDR_WIDTH-1:0] Addr1,
   input  logic [DATA_WIDTH-1:0] Data0,
   input  logic [DATA_WIDTH-1:0] Data1,
   output logic [NUM_REQ-1:0]    Ack,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic [NUM_REGS-1:0]   Enbar,
   output logic                  Busy
);

   state_t                state_q, state_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic [NUM_REQ-1:0]    pick_gnt_c;
   logic [NUM_REQ-1:0]    ack_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic [NUM_REGS-1:0]   enbar_d;
   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0] sel_data_c;

`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
   logic ptr_q, ptr_d;

   register_load_arbiter_pick u_pick (
      .req     (Req),
      .ptr     (ptr_q),
      .grant_c (pick_gnt_c)
   );
`else
   register_load_arbiter_pick u_pick (
      .req     (Req),
      .grant_c (pick_gnt_c)
   );
`endif

   // Next state and next output values; outputs are flopped below.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      data_d     = DataOut;
      enbar_d    = '1;
      ack_d      = '0;
      sel_addr_c = pick_gnt_c[1] ? Addr1 : Addr0;
      sel_data_c = pick_gnt_c[1] ? Data1 : Data0;
`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
      ptr_d      = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|Req) begin
               state_d = ST_LOAD;
               gnt_d   = pick_gnt_c;
               data_d  = sel_data_c;
               enbar_d = ~(NUM_REGS'(1) << sel_addr_c);
`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
               ptr_d   = pick_gnt_c[0];
`endif
            end
         end
         ST_LOAD: begin
            state_d = ST_ACK;
            ack_d   = gnt_q;
         end
         ST_ACK: begin
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            // Hold off re-arbitration until the served requester lets go.
            if ((Req & gnt_q) == '0) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         Ack     <= '0;
         DataOut <= '0;
         Enbar   <= '1;
         Busy    <= 1'b0;
`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
         ptr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         Ack     <= ack_d;
         DataOut <= data_d;
         Enbar   <= enbar_d;
         Busy    <= (state_d != ST_IDLE);
`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_register_load_arbiter.sv
// Scoreboard bench: driver predicts write order into a queue, monitor checks
// every bus load and the Ack pulse that must follow it.
module tb_register_load_arbiter;

   localparam int unsigned DW = 1;
   localparam int unsigned AW = 2;
   localparam int unsigned NR = 4;
   localparam logic [NR-1:0] ALL1 = '1;

`ifdef REGISTER_LOAD_ARBITER_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic          Clk;
   logic          Reset;
   logic [1:0]    Req;
   logic [AW-1:0] Addr0, Addr1;
   logic [DW-1:0] Data0, Data1;
   logic [1:0]    Ack;
   logic [DW-1:0] DataOut;
   logic [NR-1:0] Enbar;
   logic          Busy;

   register_load_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Req     (Req),
      .Addr0   (Addr0),
      .Addr1   (Addr1),
      .Data0   (Data0),
      .Data1   (Data1),
      .Ack     (Ack),
      .DataOut (DataOut),
      .Enbar   (Enbar),
      .Busy    (Busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      int            who;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [NR-1:0] mon_en;
   logic [1:0]    exp_ack = 2'b00;
   int            total   = 0;
   int            bad     = 0;
   int            rr_ptr  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are stable at the falling edge.
   always @(negedge Clk) begin
      if (Reset) begin
         chk("rst_enbar", 32'(Enbar), 32'(ALL1));
         chk("rst_ack", 32'(Ack), 32'd0);
         chk("rst_dataout", 32'(DataOut), 32'd0);
         chk("rst_busy", 32'(Busy), 32'd0);
         exp_ack = 2'b00;
      end else begin
         if (exp_ack != 2'b00 || Ack != 2'b00) chk("ack", 32'(Ack), 32'(exp_ack));
         exp_ack = 2'b00;
         if (Enbar != ALL1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_load: Enbar=%b required %b (no write pending)", Enbar, ALL1);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_en = ~(NR'(1) << mon_e.addr);
               chk("enbar", 32'(Enbar), 32'(mon_en));
               chk("dataout", 32'(DataOut), 32'(mon_e.data));
               chk("busy_load", 32'(Busy), 32'd1);
               exp_ack = 2'b01 << mon_e.who;
            end
         end
      end
   end

   // mode: 0 normal, 1 hold Req after Ack, 2 drop Req during load, 3 reset during load
   task automatic run_scen(input logic [1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input int mode, input int hold_n);
      int   order[$];
      int   first, loads, acks, cyc, who;
      bit   done;
      logic [1:0] ackd;
      exp_t e;
      if (req == 2'b11) begin
         first = RR_EN ? rr_ptr : 0;
         order.push_back(first);
         order.push_back(1 - first);
      end else begin
         order.push_back(req[1] ? 1 : 0);
      end
      foreach (order[i]) begin
         e.who  = order[i];
         e.addr = (order[i] == 1) ? a1 : a0;
         e.data = (order[i] == 1) ? d1 : d0;
         exp_q.push_back(e);
         rr_ptr = 1 - order[i];
         if (mode == 3) break;
      end
      @(negedge Clk); #1;
      Addr0 = a0; Addr1 = a1; Data0 = d0; Data1 = d1; Req = req;
      loads = 0; acks = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < 40) begin
         @(negedge Clk); #1;
         cyc++;
         if (Enbar != ALL1) begin
            if (loads == 0) chk("latency", 32'(cyc), 32'd1);
            who = order[(loads < order.size()) ? loads : order.size() - 1];
            loads++;
            // Inputs of the granted requester must not disturb the write in flight.
            if (who == 0) begin Addr0 = AW'($urandom); Data0 = DW'($urandom); end
            else          begin Addr1 = AW'($urandom); Data1 = DW'($urandom); end
            if (mode == 2) Req[who] = 1'b0;
            if (mode == 3) begin
               Reset = 1'b1; Req = 2'b00;
               @(negedge Clk); #1;
               Reset = 1'b0; rr_ptr = 0;
               repeat (3) @(negedge Clk);
               done = 1'b1;
            end
         end else if (Ack != 2'b00) begin
            acks++;
            ackd = Ack;
            if (mode == 1) begin
               repeat (hold_n) begin
                  @(negedge Clk); #1;
                  chk("hold_busy", 32'(Busy), 32'd1);
               end
               Req = Req & ~ackd;
               @(negedge Clk); #1;
               chk("hold_idle", 32'(Busy), 32'd0);
               done = 1'b1;
            end else begin
               Req = Req & ~ackd;
               if (acks == order.size()) begin
                  @(negedge Clk); #1;
                  chk("release_busy", 32'(Busy), 32'd1);
                  @(negedge Clk); #1;
                  chk("idle_busy", 32'(Busy), 32'd0);
                  done = 1'b1;
               end
            end
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout: scenario req=%b incomplete, acks=%0d required %0d", req, acks, order.size());
         Reset = 1'b1; Req = 2'b00;
         repeat (2) @(negedge Clk);
         #1 Reset = 1'b0;
         exp_q.delete();
         rr_ptr = 0;
      end
   endtask

   initial begin
      int r, m;
      Reset = 1'b1; Req = 2'b00;
      Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0;
      repeat (3) @(negedge Clk);
      #1 Reset = 1'b0;

      run_scen(2'b01, 2'd2, 2'd0, 1'b1, 1'b0, 0, 0);
      run_scen(2'b11, 2'd0, 2'd3, 1'b1, 1'b1, 0, 0);
      run_scen(2'b11, 2'd1, 2'd1, 1'b0, 1'b1, 0, 0);
      run_scen(2'b01, 2'd3, 2'd0, 1'b1, 1'b0, 1, 3);
      run_scen(2'b01, 2'd1, 2'd0, 1'b1, 1'b0, 3, 0);
      run_scen(2'b01, 2'd0, 2'd0, 1'b1, 1'b0, 2, 0);
      run_scen(2'b10, 2'd0, 2'd1, 1'b0, 1'b1, 0, 0);
      run_scen(2'b10, 2'd0, 2'd1, 1'b0, 1'b0, 0, 0);

      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(1, 3);
         m = $urandom_range(0, 9);
         m = (m <= 5) ? 0 : (m <= 7) ? 2 : (m == 8) ? 1 : 3;
         if (m == 1 || m == 3) r = $urandom_range(1, 2);
         run_scen(2'(r), AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                  m, $urandom_range(1, 4));
      end

      repeat (3) @(negedge Clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
